// File: rtl/sme_param.sv
// sme_param: streaming string/pattern matcher supporting '.', '^' and '$' metacharacters.
// Defining SME_PARAM_STAR_EN adds '*' (zero or more characters) with backtracking.
module sme_param #(
    parameter int CW      = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IW      = $clog2(STR_MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] chardata,
    input  logic          isstring,
    input  logic          ispattern,
    output logic          match,
    output logic [IW-1:0] match_index,
    output logic          valid,
    output logic          busy
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_STR = 3'd1,
        LOAD_PAT = 3'd2,
        CALC     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int LW  = ((IW > PIW) ? IW : PIW) + 1;

    localparam logic [IW:0]    S_ZERO  = (IW+1)'(0);
    localparam logic [IW:0]    S_ONE   = (IW+1)'(1);
    localparam logic [IW:0]    STR_LIM = (IW+1)'(STR_MAX);
    localparam logic [IW-1:0]  SA_ZERO = IW'(0);
    localparam logic [IW-1:0]  SA_ONE  = IW'(1);
    localparam logic [PIW:0]   P_ZERO  = (PIW+1)'(0);
    localparam logic [PIW:0]   P_ONE   = (PIW+1)'(1);
    localparam logic [PIW:0]   PAT_LIM = (PIW+1)'(PAT_MAX);
    localparam logic [PIW-1:0] PA_ZERO = PIW'(0);

    localparam logic [CW-1:0] CH_SPACE  = CW'(8'h20);
    localparam logic [CW-1:0] CH_DOT    = CW'(8'h2E);
    localparam logic [CW-1:0] CH_CARET  = CW'(8'h5E);
    localparam logic [CW-1:0] CH_DOLLAR = CW'(8'h24);

    state_t        state_r;
    logic [CW-1:0] str_r [STR_MAX];
    logic [CW-1:0] pat_r [PAT_MAX];
    logic [IW:0]   slen_r;
    logic [IW:0]   start_r;
    logic [IW:0]   sidx_r;
    logic [IW-1:0] first_r;
    logic          first_set_r;
    logic [PIW:0]  plen_r;
    logic [PIW:0]  pidx_r;

    logic          take_pat_s, take_str_s, str_we_s, pat_we_s;
    logic [IW-1:0] str_wa_s;
    logic [PIW-1:0] pat_wa_s;
    logic [PIW:0]  last_s, elems_s, mlen_s;
    logic [IW:0]   rem_s;
    logic          anchor_s_s, anchor_e_s, no_room_s;
    logic [CW-1:0] pch_s, sch_s, prev_s;
    logic [IW-1:0] prev_a_s, res_idx_s;
    logic          in_str_s, is_caret_s, is_dollar_s, final_s;
    logic          elem_ok_s, consume_s;

`ifdef SME_PARAM_STAR_EN
    localparam logic [CW-1:0] CH_STAR = CW'(8'h2A);

    logic [IW:0]   star_sidx_r;
    logic [PIW:0]  star_pidx_r;
    logic          have_star_r, star_first_set_r;
    logic [PIW:0]  nstar_s;
    logic          is_star_s, can_back_s;

    // Count '*' elements: they consume nothing, so they do not add to the minimum length.
    always_comb begin
        nstar_s = P_ZERO;
        for (int k = 0; k < PAT_MAX; k++) begin
            nstar_s = nstar_s + ((((PIW+1)'(k) < plen_r) && (pat_r[k] == CH_STAR)) ? P_ONE : P_ZERO);
        end
    end

    assign is_star_s  = !is_caret_s && !is_dollar_s && (pch_s == CH_STAR);
    assign can_back_s = have_star_r && (star_sidx_r < slen_r);
    assign mlen_s     = elems_s - nstar_s;
`else
    assign mlen_s     = elems_s;
`endif

    // ispattern wins over isstring; strobes are only accepted while loading.
    assign take_pat_s = ispattern && ((state_r == IDLE) || (state_r == LOAD_STR) || (state_r == LOAD_PAT));
    assign take_str_s = isstring && !ispattern && ((state_r == IDLE) || (state_r == LOAD_STR));
    assign str_we_s   = take_str_s && ((state_r == IDLE) || (slen_r < STR_LIM));
    assign str_wa_s   = (state_r == IDLE) ? SA_ZERO : slen_r[IW-1:0];
    assign pat_we_s   = take_pat_s && ((state_r != LOAD_PAT) || (plen_r < PAT_LIM));
    assign pat_wa_s   = (state_r == LOAD_PAT) ? plen_r[PIW-1:0] : PA_ZERO;

    assign last_s     = plen_r - P_ONE;
    assign anchor_s_s = (plen_r != P_ZERO) && (pat_r[PA_ZERO] == CH_CARET);
    assign anchor_e_s = (plen_r != P_ZERO) && (pat_r[last_s[PIW-1:0]] == CH_DOLLAR);
    assign elems_s    = plen_r - (anchor_s_s ? P_ONE : P_ZERO) - (anchor_e_s ? P_ONE : P_ZERO);
    assign rem_s      = slen_r - start_r;
    assign no_room_s  = (elems_s == P_ZERO) || (start_r >= slen_r) || (LW'(rem_s) < LW'(mlen_s));

    assign pch_s       = pat_r[pidx_r[PIW-1:0]];
    assign in_str_s    = sidx_r < slen_r;
    assign sch_s       = in_str_s ? str_r[sidx_r[IW-1:0]] : {CW{1'b0}};
    assign prev_a_s    = sidx_r[IW-1:0] - SA_ONE;
    assign prev_s      = str_r[prev_a_s];
    assign is_caret_s  = (pidx_r == P_ZERO) && anchor_s_s;
    assign is_dollar_s = (pidx_r == last_s) && anchor_e_s;
    assign final_s     = pidx_r == last_s;

    // Evaluate the current pattern element against the current string position.
    always_comb begin
        elem_ok_s = 1'b0;
        consume_s = 1'b0;
        if (is_caret_s) begin
            elem_ok_s = (sidx_r == S_ZERO) || (prev_s == CH_SPACE);
            consume_s = 1'b0;
        end else if (is_dollar_s) begin
            elem_ok_s = !in_str_s || (sch_s == CH_SPACE);
            consume_s = 1'b0;
`ifdef SME_PARAM_STAR_EN
        end else if (is_star_s) begin
            elem_ok_s = 1'b1;
            consume_s = 1'b0;
`endif
        end else begin
            elem_ok_s = in_str_s && ((pch_s == CH_DOT) || (pch_s == sch_s));
            consume_s = 1'b1;
        end
    end

    assign res_idx_s = first_set_r ? first_r : (consume_s ? sidx_r[IW-1:0] : start_r[IW-1:0]);

    // Character storage; only the lengths qualify what is read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (str_we_s) str_r[str_wa_s] <= chardata;
        if (pat_we_s) pat_r[pat_wa_s] <= chardata;
    end

    // Control FSM, lengths, search pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            slen_r      <= S_ZERO;
            plen_r      <= P_ZERO;
            start_r     <= S_ZERO;
            sidx_r      <= S_ZERO;
            pidx_r      <= P_ZERO;
            first_r     <= SA_ZERO;
            first_set_r <= 1'b0;
            match       <= 1'b0;
            match_index <= SA_ZERO;
            valid       <= 1'b0;
            busy        <= 1'b0;
`ifdef SME_PARAM_STAR_EN
            star_sidx_r      <= S_ZERO;
            star_pidx_r      <= P_ZERO;
            have_star_r      <= 1'b0;
            star_first_set_r <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (take_pat_s) begin
                        state_r <= LOAD_PAT;
                        plen_r  <= P_ONE;
                    end else if (take_str_s) begin
                        state_r <= LOAD_STR;
                        slen_r  <= S_ONE;
                        plen_r  <= P_ZERO;
                    end
                end
                LOAD_STR: begin
                    if (take_pat_s) begin
                        state_r <= LOAD_PAT;
                        plen_r  <= P_ONE;
                    end else if (take_str_s) begin
                        if (slen_r < STR_LIM) slen_r <= slen_r + S_ONE;
                    end else begin
                        // A string-only frame searches with an empty pattern.
                        state_r     <= CALC;
                        busy        <= 1'b1;
                        start_r     <= S_ZERO;
                        sidx_r      <= S_ZERO;
                        pidx_r      <= P_ZERO;
                        first_set_r <= 1'b0;
`ifdef SME_PARAM_STAR_EN
                        have_star_r <= 1'b0;
`endif
                    end
                end
                LOAD_PAT: begin
                    if (ispattern) begin
                        if (plen_r < PAT_LIM) plen_r <= plen_r + P_ONE;
                    end else if (!isstring) begin
                        state_r     <= CALC;
                        busy        <= 1'b1;
                        start_r     <= S_ZERO;
                        sidx_r      <= S_ZERO;
                        pidx_r      <= P_ZERO;
                        first_set_r <= 1'b0;
`ifdef SME_PARAM_STAR_EN
                        have_star_r <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    if ((pidx_r == P_ZERO) && no_room_s) begin
                        state_r     <= DONE;
                        valid       <= 1'b1;
                        match       <= 1'b0;
                        match_index <= SA_ZERO;
                    end else if (elem_ok_s) begin
                        if (final_s) begin
                            state_r     <= DONE;
                            valid       <= 1'b1;
                            match       <= 1'b1;
                            match_index <= res_idx_s;
                        end else begin
                            pidx_r <= pidx_r + P_ONE;
                            if (consume_s) sidx_r <= sidx_r + S_ONE;
                            if (consume_s && !first_set_r) begin
                                first_r     <= sidx_r[IW-1:0];
                                first_set_r <= 1'b1;
                            end
`ifdef SME_PARAM_STAR_EN
                            if (is_star_s) begin
                                star_pidx_r      <= pidx_r + P_ONE;
                                star_sidx_r      <= sidx_r;
                                have_star_r      <= 1'b1;
                                star_first_set_r <= first_set_r;
                            end
`endif
                        end
`ifdef SME_PARAM_STAR_EN
                    end else if (can_back_s) begin
                        // Let the most recent '*' swallow one more character and retry after it.
                        star_sidx_r <= star_sidx_r + S_ONE;
                        sidx_r      <= star_sidx_r + S_ONE;
                        pidx_r      <= star_pidx_r;
                        first_set_r <= star_first_set_r;
`endif
                    end else begin
                        start_r     <= start_r + S_ONE;
                        sidx_r      <= start_r + S_ONE;
                        pidx_r      <= P_ZERO;
                        first_set_r <= 1'b0;
`ifdef SME_PARAM_STAR_EN
                        have_star_r <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_param.sv
// Directed self-checking bench for sme_param with default parameters.
module tb_sme_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] chardata = 8'h00;
    logic       isstring = 1'b0;
    logic       ispattern = 1'b0;
    logic       match;
    logic [4:0] match_index;
    logic       valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sme_param dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .match(match), .match_index(match_index),
        .valid(valid), .busy(busy)
    );

    task automatic drive_frame(input bit with_str, input string s, input string p);
        if (with_str) begin
            for (int i = 0; i < s.len(); i++) begin
                @(posedge clk); #1;
                isstring = 1'b1; ispattern = 1'b0; chardata = s[i];
            end
        end
        for (int i = 0; i < p.len(); i++) begin
            @(posedge clk); #1;
            isstring = 1'b0; ispattern = 1'b1; chardata = p[i];
        end
        @(posedge clk); #1;
        isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    endtask

    task automatic wait_result(output bit got, output bit m, output logic [4:0] idx, output int cyc);
        got = 1'b0; m = 1'b0; idx = 5'd0; cyc = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            cyc = c + 1;
            if (valid === 1'b1) begin
                got = 1'b1; m = match; idx = match_index;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if ({match, match_index, valid, busy} !== 8'h00) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 00000000", {match, match_index, valid, busy});
        end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_basic;
        bit got, m; logic [4:0] idx; int cyc;
        drive_frame(1'b1, "hello world", "wor");
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_result(got, m, idx, cyc);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", got); end
        n_cmp++; if ({m, idx} !== {1'b1, 5'd6}) begin n_bad++; $display("FAIL basic_wor: got %b/%0d want 1/6", m, idx); end
        @(negedge clk);
        n_cmp++; if ({valid, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_pulse: valid/busy %b want 00", {valid, busy}); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({match, match_index} !== {1'b1, 5'd6}) begin
            n_bad++; $display("FAIL basic_hold: got %b/%0d want 1/6", match, match_index);
        end
    endtask

    task automatic test_reuse;
        bit got, m; logic [4:0] idx; int cyc;
        drive_frame(1'b0, "", "^w.r");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd6}) begin n_bad++; $display("FAIL reuse_caret: got %b%b/%0d want 11/6", got, m, idx); end
        drive_frame(1'b0, "", "o$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd4}) begin n_bad++; $display("FAIL reuse_dollar: got %b%b/%0d want 11/4", got, m, idx); end
    endtask

    task automatic test_nomatch;
        bit got, m; logic [4:0] idx; int cyc;
        drive_frame(1'b1, "abc", "abcd");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL nomatch_long: got %b%b/%0d want 10/0", got, m, idx); end
        drive_frame(1'b1, "abc", "");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL nomatch_empty: got %b%b/%0d want 10/0", got, m, idx); end
        drive_frame(1'b0, "", "bc$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd1}) begin n_bad++; $display("FAIL nomatch_bc: got %b%b/%0d want 11/1", got, m, idx); end
        drive_frame(1'b0, "", "^$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL nomatch_anchors: got %b%b/%0d want 10/0", got, m, idx); end
    endtask

    task automatic test_overflow;
        bit got, m; logic [4:0] idx; int cyc;
        drive_frame(1'b1, "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMN", "EF");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd30}) begin n_bad++; $display("FAIL ovf_ef: got %b%b/%0d want 11/30", got, m, idx); end
        drive_frame(1'b0, "", "FG");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL ovf_fg: got %b%b/%0d want 10/0", got, m, idx); end
        drive_frame(1'b0, "", "F$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd31}) begin n_bad++; $display("FAIL ovf_end: got %b%b/%0d want 11/31", got, m, idx); end
        drive_frame(1'b0, "", "abcdefghXY");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd0}) begin n_bad++; $display("FAIL ovf_pat: got %b%b/%0d want 11/0", got, m, idx); end
    endtask

    task automatic test_back_to_back;
        bit got, m; logic [4:0] idx; int cyc;
        drive_frame(1'b1, "hello world", "^o");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b0, 5'd0}) begin n_bad++; $display("FAIL b2b_caret_o: got %b%b/%0d want 10/0", got, m, idx); end
        n_cmp++; if (cyc > 290) begin n_bad++; $display("FAIL b2b_latency: got %0d cycles want <= 290", cyc); end
        drive_frame(1'b0, "", "d$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd10}) begin n_bad++; $display("FAIL b2b_d_end: got %b%b/%0d want 11/10", got, m, idx); end
        drive_frame(1'b0, "", "world$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd6}) begin n_bad++; $display("FAIL b2b_world: got %b%b/%0d want 11/6", got, m, idx); end
        drive_frame(1'b0, "", "l.o");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd2}) begin n_bad++; $display("FAIL b2b_dot: got %b%b/%0d want 11/2", got, m, idx); end
    endtask

    task automatic test_reset_mid_calc;
        bit got, m; logic [4:0] idx; int cyc;
        int seen = 0;
        drive_frame(1'b1, "aaaaaaaaaaaaaaaaaaaa", "aaaaaaab");
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_calc_busy: got %b want 1", busy); end
        reset = 1'b1;
        #2;
        n_cmp++; if ({match, match_index, valid, busy} !== 8'h00) begin
            n_bad++; $display("FAIL rst_calc_outputs: got %b want 00000000", {match, match_index, valid, busy});
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_calc_novalid: got %0d pulses want 0", seen); end
        drive_frame(1'b1, "ab", "b");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, 5'd1}) begin n_bad++; $display("FAIL rst_calc_next: got %b%b/%0d want 11/1", got, m, idx); end
    endtask

    task automatic test_star;
        bit got, m; logic [4:0] idx; int cyc;
        bit exp_m; logic [4:0] exp_idx;
`ifdef SME_PARAM_STAR_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        drive_frame(1'b1, "cat hat", "c*t$");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, exp_m, 5'd0}) begin n_bad++; $display("FAIL star_cat: got %b%b/%0d want 1%b/0", got, m, idx, exp_m); end
`ifdef SME_PARAM_STAR_EN
        exp_idx = 5'd2;
`else
        exp_idx = 5'd1;
`endif
        drive_frame(1'b1, "a*b", "*b");
        wait_result(got, m, idx, cyc);
        n_cmp++; if ({got, m, idx} !== {1'b1, 1'b1, exp_idx}) begin n_bad++; $display("FAIL star_lit: got %b%b/%0d want 11/%0d", got, m, idx, exp_idx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reuse();
        test_nomatch();
        test_overflow();
        test_back_to_back();
        test_reset_mid_calc();
        test_star();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
